// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ready handshake,
// and presents one registered instruction downstream with stall, branch flush and halt.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic [5:0]        opcode,
    output logic              halted
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic              xfer;
    logic              branch_go;

    // A request is only raised when the output register can take the word next edge.
    assign imem_req  = (state_q == S_FETCH) && !halt && !branch_taken
                       && (!instr_valid_q || !stall);
    assign xfer      = imem_req && imem_ready;
    assign branch_go = branch_taken && !halt && (state_q != S_HALT);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (halt) state_d = S_HALT;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        if (branch_go) begin
            pc_d          = branch_target & ~ADDR_W'(3);
            instr_d       = 32'h0;
            instr_valid_d = 1'b0;
        end else if (xfer) begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + ADDR_W'(PC_INC);
        end else if (instr_valid_q && !stall) begin
            // Consumed with nothing to refill; the word itself is left in place.
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign opcode      = instr_q[31:26];
    assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus pushes expected instructions into a queue,
// a negedge monitor pops and checks every instruction consumed downstream.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        halt = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic        halted;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic        w_valid;
    logic [5:0]  w_opcode;
    logic        w_halted;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .PC_INC(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .halt(halt),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .opcode(opcode), .halted(halted)
    );

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .PC_INC(4)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(1'b1), .imem_rdata(32'h8C01_0004),
        .stall(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
        .halt(1'b0),
        .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_valid),
        .opcode(w_opcode), .halted(w_halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] pc, input logic [31:0] word);
        exp_q.push_back({pc, word});
    endtask

    // Monitor: an instruction is handed downstream on any edge where it is valid and not stalled.
    always @(negedge clk) begin
        if (!rst && instr_valid && !stall && !branch_taken) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got instr %h pc %h want none", instr, instr_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("sb_instr", instr, e[31:0]);
                chk("sb_pc", instr_pc, e[63:32]);
                chk("sb_opcode", {26'h0, opcode}, {26'h0, e[31:26]});
            end
        end
    end

    initial begin
        // Reset state
        #2;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rel_addr", imem_addr, 32'h0);
        chk("rel_req_c1", {31'h0, imem_req}, 32'h0);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        step();
        chk("rel_req_c2", {31'h0, imem_req}, 32'h1);

        // Streaming, back-to-back
        imem_ready = 1'b1;
        imem_rdata = 32'h8C01_0004;
        expect_word(32'h0, 32'h8C01_0004);
        #1;
        chk("s_addr0", imem_addr, 32'h0);
        chk("wrap_req", {31'h0, w_req}, 32'h1);
        step();
        chk("s_valid0", {31'h0, instr_valid}, 32'h1);
        chk("s_op0", {26'h0, opcode}, 32'd35);
        chk("s_addr1", imem_addr, 32'h4);
        chk("wrap_addr1", w_addr, 32'h0);
        chk("wrap_ipc", w_instr_pc, 32'hFFFF_FFFC);
        imem_rdata = 32'hAC02_0008;
        expect_word(32'h4, 32'hAC02_0008);
        step();
        chk("s_op1", {26'h0, opcode}, 32'd43);
        chk("s_ipc1", instr_pc, 32'h4);

        // Stall with a live instruction
        stall = 1'b1;
        imem_rdata = 32'h1111_1111;
        #1;
        chk("st_req", {31'h0, imem_req}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_instr", instr, 32'hAC02_0008);
            chk("st_ipc", instr_pc, 32'h4);
            chk("st_valid", {31'h0, instr_valid}, 32'h1);
            chk("st_req_hold", {31'h0, imem_req}, 32'h0);
        end
        stall = 1'b0;
        imem_rdata = 32'h2003_0005;
        expect_word(32'h8, 32'h2003_0005);
        step();
        chk("st_nobubble_instr", instr, 32'h2003_0005);
        chk("st_nobubble_valid", {31'h0, instr_valid}, 32'h1);
        imem_ready = 1'b0;

        // Wait states
        step();
        chk("ws_valid_drop", {31'h0, instr_valid}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            chk("ws_req", {31'h0, imem_req}, 32'h1);
            chk("ws_addr", imem_addr, 32'hC);
            step();
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h8C04_0010;
        expect_word(32'hC, 32'h8C04_0010);
        step();
        chk("ws_cap_ipc", instr_pc, 32'hC);
        imem_ready = 1'b0;
        step();
        chk("ws_addr_next", imem_addr, 32'h10);

        // Branch with a same-cycle returned word
        branch_taken = 1'b1;
        branch_target = 32'h0000_0043;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("br_req", {31'h0, imem_req}, 32'h0);
        step();
        chk("br_instr", instr, 32'h0);
        chk("br_valid", {31'h0, instr_valid}, 32'h0);
        chk("br_addr", imem_addr, 32'h40);
        branch_taken = 1'b0;
        imem_rdata = 32'hAC05_0014;
        expect_word(32'h40, 32'hAC05_0014);
        step();
        chk("br_fetch_ipc", instr_pc, 32'h40);
        imem_ready = 1'b0;
        step();
        chk("br_addr_next", imem_addr, 32'h44);

        // Asynchronous reset in the middle of a fetch
        imem_ready = 1'b1;
        imem_rdata = 32'h8C06_0018;
        step();
        stall = 1'b1;
        imem_ready = 1'b0;
        #1;
        chk("ar_pre_valid", {31'h0, instr_valid}, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_valid", {31'h0, instr_valid}, 32'h0);
        chk("ar_instr", instr, 32'h0);
        chk("ar_ipc", instr_pc, 32'h0);
        chk("ar_addr", imem_addr, 32'h0);
        chk("ar_req", {31'h0, imem_req}, 32'h0);
        step();
        rst = 1'b0;
        stall = 1'b0;
        #1;
        chk("ar_rel_req", {31'h0, imem_req}, 32'h0);
        step();
        chk("ar_req_c2", {31'h0, imem_req}, 32'h1);

        // Halt: same-cycle effect, current word still drains
        imem_ready = 1'b1;
        imem_rdata = 32'h8C07_0000;
        expect_word(32'h0, 32'h8C07_0000);
        step();
        halt = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("h_req_same", {31'h0, imem_req}, 32'h0);
        step();
        chk("h_halted", {31'h0, halted}, 32'h1);
        chk("h_drained", {31'h0, instr_valid}, 32'h0);
        chk("h_instr_kept", instr, 32'h8C07_0000);
        chk("h_addr", imem_addr, 32'h4);
        halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("h_req_off", {31'h0, imem_req}, 32'h0);
            chk("h_sticky", {31'h0, halted}, 32'h1);
            chk("h_addr_hold", imem_addr, 32'h4);
        end

        chk("sb_empty", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
